mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequences and shares the single unified memory port of the multicycle MIPS core between two requesters: the instruction-fetch side and the data (lw/sw) side. It replaces the fixed iord steering with a request/ready handshake. It grants one transaction at a time with round-robin on ties, drives the memory for a programmable latency, and returns read data to the owning port.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
i_req  in  1  fetch request, held until i_ready
i_addr  in  AW  fetch address, stable while i_req=1
i_ready  out  1  one-cycle fetch completion pulse
i_rdata  out  DW  fetched word; valid with i_ready, held until next fetch completes
d_req  in  1  data request, held until d_ready
d_we  in  1  1=store, 0=load; stable while d_req=1
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ready  out  1  one-cycle data completion pulse
d_rdata  out  DW  load word; valid with d_ready, held until next load completes
mem_en  out  1  memory access strobe, exactly one cycle per transaction
mem_we  out  1  write enable, only ever high together with mem_en
mem_addr  out  AW  memory address (latched copy)
mem_wdata  out  DW  memory write data (latched copy)
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  out  1  1 whenever state != IDLE
owner  out  1  current or last grantee: 0=fetch, 1=data

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; all outputs 0, including i_rdata, d_rdata, mem_addr and mem_wdata.
  - last_grant=DATA, so the first tie goes to fetch.
  - The wait counter is cleared.
- IDLE:
  - Samples i_req and d_req.
  - Neither request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port that is not last_grant.
  - On a grant: latch addr, we (0 for fetch) and wdata; set owner and last_grant; go to ISSUE.
- ISSUE: exactly one cycle.
  - mem_en=1; mem_we=latched we; mem_addr and mem_wdata driven from the latches.
  - Counter loaded with MEM_LAT; next state WAIT.
- WAIT: lasts MEM_LAT cycles.
  - mem_en=0; the counter decrements each cycle.
  - In the final WAIT cycle (counter=1), a read captures mem_rdata into the owner's rdata register. A write captures nothing.
  - Next state RESP.
- RESP: exactly one cycle.
  - owner's ready=1; next state IDLE.
  - The requester may change req, addr and data from the next edge onward.
  - req is not sampled in RESP. A req still high in the following IDLE cycle is a new transaction.
- Latency:
  - req sampled in IDLE at cycle 0, mem_en at cycle 1, ready at cycle 2+MEM_LAT.
  - Back-to-back throughput is one transaction per 3+MEM_LAT cycles.
- Writes take the same path. d_rdata is unchanged by a store. i_rdata changes only on fetch completion.
- Requests arriving mid-transaction wait; no request is dropped. Round-robin on ties guarantees no starvation.
- Reset mid-transaction: the next state is IDLE with no ready pulse, and the in-flight read result is discarded. A store already strobed is not undone.
- Outputs are registered from state and latches: no combinational path from req to mem_* or to ready.

Decomposition:
- Shared package:
  - state encoding localparams IDLE/ISSUE/WAIT/RESP (2 bits);
  - owner encoding OWN_I=0, OWN_D=1;
  - a MEM_LAT range check constant.
- Single module; no sub-module. The 4-bit wait counter is inline.

Test Plan:
- Reset: hold rst 2 cycles with both reqs high -> all outputs 0, busy=0, no mem_en during or on the cycle after reset.
- Fetch read, MEM_LAT=1: i_req, i_addr=0x40 at cycle 0, memory returns 0x2002000A -> mem_en=1, mem_we=0, mem_addr=0x40 at cycle 1; i_ready=1 with i_rdata=0x2002000A at cycle 3; d_ready stays 0.
- Store: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_en=mem_we=1 with those values at cycle 1; d_ready at cycle 3; d_rdata unchanged.
- Tie after reset: both reqs held continuously -> grants alternate I, D, I, D; mem_en at cycles 1, 5, 9, 13; owner toggles accordingly.
- MEM_LAT=3 load of 0x00000007 from 0x8 -> mem_en cycle 1, d_ready and d_rdata=0x7 at cycle 5, busy high cycles 1–5.
- rst pulsed in the WAIT cycle of a fetch -> IDLE next cycle, no i_ready, i_rdata=0; a subsequent d_req is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and latency limits for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and status signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
// One transaction at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP, round-robin on ties.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam bit         LAT_OK = mem_lat_ok(MEM_LAT);
  localparam logic [3:0] LAT4   = 4'(MEM_LAT);

  if (!LAT_OK) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT out of range 1..15");
  end

  arb_state_t    r_state;
  logic [3:0]    r_cnt;
  logic          r_last_grant;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          r_i_ready;
  logic          r_d_ready;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_busy;
  logic          w_grant_d;

  // Data wins when it is the only requester, or on a tie when fetch went last.
  assign w_grant_d = bus.d_req && (!bus.i_req || (r_last_grant == OWN_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= OWN_D;
      r_owner      <= OWN_I;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            r_owner      <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_addr       <= w_grant_d ? bus.d_addr : bus.i_addr;
            r_wdata      <= w_grant_d ? bus.d_wdata : '0;
            r_we         <= w_grant_d & bus.d_we;
            r_mem_en     <= 1'b1;
            r_mem_we     <= w_grant_d & bus.d_we;
            r_busy       <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= LAT4;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (!r_we) begin
              if (r_owner == OWN_D) r_d_rdata <= bus.mem_rdata;
              else                  r_i_rdata <= bus.mem_rdata;
            end
            r_d_ready <= (r_owner == OWN_D);
            r_i_ready <= (r_owner == OWN_I);
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.i_ready   = r_i_ready;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2002_000A;
      32'h0000_0008: return 32'h0000_0007;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory models: data is valid exactly MEM_LAT cycles after the mem_en cycle.
  logic [31:0] m1_q = '0;
  logic [31:0] m3_q = '0;
  logic        m1_v = 1'b0;
  logic [2:0]  m3_sr = '0;

  always @(posedge clk) begin
    m1_v  <= bus1.mem_en;
    m3_sr <= {m3_sr[1:0], bus3.mem_en};
    if (bus1.mem_en) m1_q <= mem_word(bus1.mem_addr);
    if (bus3.mem_en) m3_q <= mem_word(bus3.mem_addr);
  end

  assign bus1.mem_rdata = m1_v     ? m1_q : 32'hFFFF_FFFF;
  assign bus3.mem_rdata = m3_sr[2] ? m3_q : 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic txn1(input logic is_d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd);
    if (is_d) begin
      bus1.d_req = 1'b1; bus1.d_we = we; bus1.d_addr = addr; bus1.d_wdata = wdata;
    end else begin
      bus1.i_req = 1'b1; bus1.i_addr = addr;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("txn_mem_en", 32'(bus1.mem_en), 32'(c == 1));
      if (c == 1) begin
        check("txn_mem_we", 32'(bus1.mem_we), 32'(we));
        check("txn_mem_addr", bus1.mem_addr, addr);
        if (we) check("txn_mem_wdata", bus1.mem_wdata, wdata);
      end
      check("txn_i_ready", 32'(bus1.i_ready), 32'(!is_d && c == 3));
      check("txn_d_ready", 32'(bus1.d_ready), 32'(is_d && c == 3));
      if (c == 3) check("txn_rdata", is_d ? bus1.d_rdata : bus1.i_rdata, exp_rd);
      next_cycle();
      if (c == 3) begin
        bus1.i_req = 1'b0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
      end
    end
  endtask

  initial begin
    bus1.i_req = 1'b1; bus1.i_addr = 32'h10;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h20; bus1.d_wdata = '0;
    bus3.i_req = 1'b0; bus3.i_addr = '0;
    bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0;

    // Reset held two edges with both requests high.
    next_cycle();
    check("rst_mem_en_during", 32'(bus1.mem_en), 32'h0);
    next_cycle();
    check("rst_mem_en", 32'(bus1.mem_en), 32'h0);
    check("rst_busy", 32'(bus1.busy), 32'h0);
    check("rst_owner", 32'(bus1.owner), 32'h0);
    check("rst_i_rdata", bus1.i_rdata, 32'h0);
    check("rst_d_rdata", bus1.d_rdata, 32'h0);
    check("rst_mem_addr", bus1.mem_addr, 32'h0);
    check("rst_mem_wdata", bus1.mem_wdata, 32'h0);
    check("rst_readies", {30'h0, bus1.i_ready, bus1.d_ready}, 32'h0);
    rst = 1'b0;

    // Tie with both held: I, D, I, D at mem_en cycles 1, 5, 9, 13.
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("tie_mem_en", 32'(bus1.mem_en), 32'(c % 4 == 1));
      if (c % 4 == 1) begin
        check("tie_owner", 32'(bus1.owner), 32'((c / 4) % 2));
        check("tie_addr", bus1.mem_addr, ((c / 4) % 2 == 1) ? 32'h20 : 32'h10);
      end
      check("tie_i_ready", 32'(bus1.i_ready), 32'(c == 3 || c == 11));
      check("tie_d_ready", 32'(bus1.d_ready), 32'(c == 7 || c == 15));
      if (c == 3) check("tie_i_rdata", bus1.i_rdata, 32'h5A5A_0010);
      if (c == 7) check("tie_d_rdata", bus1.d_rdata, 32'h5A5A_0020);
      next_cycle();
    end
    bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    next_cycle();

    txn1(1'b0, 1'b0, 32'h40, 32'h0, 32'h2002_000A);
    txn1(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h5A5A_0020);
    check("store_i_rdata_kept", bus1.i_rdata, 32'h2002_000A);

    // Reset pulsed in the WAIT cycle of a fetch.
    bus1.i_req = 1'b1; bus1.i_addr = 32'h40;
    next_cycle();
    next_cycle();
    rst = 1'b1; bus1.i_req = 1'b0;
    @(negedge clk);
    check("rstw_busy_wait", 32'(bus1.busy), 32'h1);
    next_cycle();
    rst = 1'b0;
    check("rstw_busy", 32'(bus1.busy), 32'h0);
    check("rstw_i_ready", 32'(bus1.i_ready), 32'h0);
    check("rstw_i_rdata", bus1.i_rdata, 32'h0);
    next_cycle();
    check("rstw_i_ready_late", 32'(bus1.i_ready), 32'h0);
    check("rstw_mem_en", 32'(bus1.mem_en), 32'h0);
    txn1(1'b1, 1'b0, 32'h20, 32'h0, 32'h5A5A_0020);
    check("rstw_i_rdata_after", bus1.i_rdata, 32'h0);

    // MEM_LAT=3 load.
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h8;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("lat3_mem_en", 32'(bus3.mem_en), 32'(c == 1));
      check("lat3_busy", 32'(bus3.busy), 32'(c >= 1 && c <= 5));
      check("lat3_d_ready", 32'(bus3.d_ready), 32'(c == 5));
      if (c == 5) check("lat3_d_rdata", bus3.d_rdata, 32'h0000_0007);
      next_cycle();
      if (c == 5) bus3.d_req = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
